// File: rtl/screen_ram_arbiter_if.sv
// rtl/screen_ram_arbiter_if.sv - CPU, video and RAM buses of the screen RAM arbiter
//
// Signals:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> arbiter   processor access request
//   cpu_rdata/cpu_ack/cpu_en          <- arbiter   read data, completion pulse, CPU-rate enable
//   vid_req/vid_ma/vid_ra/wrap_sel    -> arbiter   CRTC fetch request and screen geometry
//   vid_data/vid_valid                <- arbiter   fetched byte and its strobe
//   ram_en/ram_we/ram_addr/ram_wdata  <- arbiter   single-port RAM control
//   ram_rdata                         -> arbiter   synchronous RAM read data
// Modports: slave = arbiter side, master = environment (CPU, CRTC and RAM).
interface screen_ram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_en;

    logic              vid_req;
    logic [13:0]       vid_ma;
    logic [2:0]        vid_ra;
    logic [1:0]        wrap_sel;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_en,
        input  vid_req, vid_ma, vid_ra, wrap_sel,
        output vid_data, vid_valid,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_en,
        output vid_req, vid_ma, vid_ra, wrap_sel,
        input  vid_data, vid_valid,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/screen_ram_arbiter.sv
// rtl/screen_ram_arbiter.sv - time-division arbiter for the shared screen/program RAM
//
// Ports:
//   clk16MHz  master clock, rising edge
//   RESET     synchronous active-high reset
//   bus       screen_ram_arbiter_if.slave (CPU, video and RAM buses)
//
// Each CPU cycle is PHASES master clocks. Phase 0 samples the video request and
// issues the RAM access (visible at phase 1); the byte is captured at the end of
// phase 2 (visible at phase 3). The CPU slot repeats this pattern starting at
// phase PHASES/2. cpu_en is registered so that it is high during phase PHASES-1.
module screen_ram_arbiter #(
    parameter int                ADDR_W   = 15,
    parameter int                DATA_W   = 8,
    parameter int                PHASES   = 8,
    parameter logic [ADDR_W-1:0] TTX_BASE = 15'h7C00
) (
    input  logic                 clk16MHz,
    input  logic                 RESET,
    screen_ram_arbiter_if.slave  bus
);
    localparam int PW = $clog2(PHASES);
    localparam int H  = PHASES / 2;

    localparam logic [PW-1:0] PH_VID_ISSUE = PW'(0);
    localparam logic [PW-1:0] PH_VID_CAPT  = PW'(2);
    localparam logic [PW-1:0] PH_CPU_ISSUE = PW'(H);
    localparam logic [PW-1:0] PH_CPU_CAPT  = PW'(H + 2);
    localparam logic [PW-1:0] PH_EN_PRE    = PW'(PHASES - 2);

    generate
        if (PHASES < 8 || (PHASES & (PHASES - 1)) != 0) begin : g_bad_phases
            $error("screen_ram_arbiter: PHASES must be a power of two and at least 8");
        end
    endgenerate

    logic [PW-1:0]     phase;
    logic              vid_pend;
    logic              cpu_pend;
    logic              cpu_pend_we;

    // Video address translation. Bitmap addresses with MA[12] set have run off
    // the top of RAM and are folded back into the screen area by adding
    // (RAM size - screen size); the subtraction is done modulo 2^ADDR_W.
    logic [ADDR_W-1:0] wrap_off;
    logic [ADDR_W-1:0] raw_addr;
    logic [ADDR_W-1:0] vphys;

    always_comb begin
        wrap_off = '0;
        case (bus.wrap_sel)
            2'd0:    wrap_off = ADDR_W'(32'd0 - 32'd20480);
            2'd1:    wrap_off = ADDR_W'(32'd0 - 32'd16384);
            2'd2:    wrap_off = ADDR_W'(32'd0 - 32'd10240);
            default: wrap_off = ADDR_W'(32'd0 - 32'd8192);
        endcase
    end

    always_comb begin
        raw_addr = {bus.vid_ma[ADDR_W-4:0], bus.vid_ra};
        vphys    = raw_addr;
        if (bus.vid_ma[13]) begin
            vphys = TTX_BASE + ADDR_W'(bus.vid_ma[9:0]);
        end else if (bus.vid_ma[12]) begin
            vphys = raw_addr + wrap_off;
        end
    end

    always_ff @(posedge clk16MHz) begin
        if (RESET) begin
            phase         <= '0;
            vid_pend      <= 1'b0;
            cpu_pend      <= 1'b0;
            cpu_pend_we   <= 1'b0;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.vid_data  <= '0;
            bus.vid_valid <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_en    <= 1'b0;
        end else begin
            // PHASES is a power of two, so the counter wraps naturally.
            phase <= phase + PW'(1);

            // Strobes default low so each lasts exactly one clock.
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_wdata <= '0;
            bus.vid_valid <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_en    <= (phase == PH_EN_PRE);

            if (phase == PH_VID_ISSUE && bus.vid_req) begin
                bus.ram_en   <= 1'b1;
                bus.ram_addr <= vphys;
                vid_pend     <= 1'b1;
            end

            if (phase == PH_VID_CAPT && vid_pend) begin
                bus.vid_data  <= bus.ram_rdata;
                bus.vid_valid <= 1'b1;
                vid_pend      <= 1'b0;
            end

            if (phase == PH_CPU_ISSUE && bus.cpu_req) begin
                bus.ram_en   <= 1'b1;
                bus.ram_we   <= bus.cpu_we;
                bus.ram_addr <= bus.cpu_addr;
                if (bus.cpu_we) begin
                    bus.ram_wdata <= bus.cpu_wdata;
                end
                cpu_pend    <= 1'b1;
                cpu_pend_we <= bus.cpu_we;
            end

            // Writes complete with an ack only; the read-data register keeps
            // the result of the last read.
            if (phase == PH_CPU_CAPT && cpu_pend) begin
                bus.cpu_ack <= 1'b1;
                if (!cpu_pend_we) begin
                    bus.cpu_rdata <= bus.ram_rdata;
                end
                cpu_pend <= 1'b0;
            end
        end
    end
endmodule
